// File: rtl/sweep_pkg.sv
// ---------------------------------------------------------------------------
// sweep_pkg
// Shared definitions for abcd_sweep_sequencer and its hold timer:
//   state_t              sequencer FSM states
//   DEF_WIDTH            default vector width (4 -> inputs A..D)
//   DEF_HOLD_CYCLES      default transfer-to-transfer spacing (1 = back-to-back)
//   last_vec(width)      all-ones value of a width-bit vector (final sweep vector)
// ---------------------------------------------------------------------------
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    PRESENT = 3'd1,
    HOLD    = 3'd2,
    PAUSE   = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_HOLD_CYCLES = 1;

  // Built bit by bit so a width of 32 does not overflow a shift.
  function automatic logic [31:0] last_vec(input int width);
    logic [31:0] v;
    v = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) v[i] = 1'b1;
    end
    return v;
  endfunction

endpackage

// File: rtl/sweep_hold_timer.sv
// ---------------------------------------------------------------------------
// sweep_hold_timer
// Loadable down-counter that times the valid-low gap between transfers.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   asynchronous active-low reset (count -> 0)
//   load     in   load LOAD_VAL into the counter
//   en       in   count down by one (saturates at zero)
//   expired  out  terminal count reached (count == 0)
// ---------------------------------------------------------------------------
module sweep_hold_timer
  import sweep_pkg::*;
#(
  parameter int            CW       = 1,
  parameter logic [CW-1:0] LOAD_VAL = '0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic en,
  output logic expired
);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= LOAD_VAL;
    end else if (en && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/abcd_sweep_sequencer.sv
// ---------------------------------------------------------------------------
// abcd_sweep_sequencer
// Sweeps a WIDTH-bit stimulus vector from 0 to all-ones under a valid/ready
// handshake, either free-running or one vector per step pulse, and optionally
// captures the decoder outputs F1/F2 per vector.
//
// Optional feature macro: SWEEP_RESULT_CAPTURE_EN
//   defined   : result_f1/result_f2 record f1_in/f2_in at each transfer,
//               cleared when a sweep starts
//   undefined : result words tied to 0, f1_in/f2_in ignored
//
// Ports:
//   clk, rst_n            clock (rising edge), async active-low reset
//   start                 begin a sweep (IDLE only); step_mode latched then
//   step_mode             0 = free sweep, 1 = single-step
//   step                  advance one vector (PAUSE only, never queued)
//   abort                 return to IDLE from any busy state
//   vec_out, vec_valid    current vector and its valid flag
//   vec_ready             downstream accept; transfer = vec_valid && vec_ready
//   busy                  high outside IDLE
//   done                  one-cycle pulse after the final transfer
//   f1_in, f2_in          decoder outputs for vec_out
//   result_f1, result_f2  captured outputs, bit i = vector i
//
// State     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for start, vec_valid low
// PRESENT   | vec_valid high, vec_out stable until a transfer
// HOLD      | valid-low gap of HOLD_CYCLES-1 cycles between vectors
// PAUSE     | single-step mode, waiting for step
// DONE      | final vector transferred, done pulse, back to IDLE
// ---------------------------------------------------------------------------
module abcd_sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  step_mode,
  input  logic                  step,
  input  logic                  abort,
  output logic [WIDTH-1:0]      vec_out,
  output logic                  vec_valid,
  input  logic                  vec_ready,
  output logic                  busy,
  output logic                  done,
  input  logic                  f1_in,
  input  logic                  f2_in,
  output logic [(1<<WIDTH)-1:0] result_f1,
  output logic [(1<<WIDTH)-1:0] result_f2
);

  localparam logic [WIDTH-1:0] LAST_VEC = WIDTH'(last_vec(WIDTH));
  localparam bit USE_HOLD = (HOLD_CYCLES > 1);

  // The first HOLD cycle is the one right after the load, so the counter
  // starts at HOLD_CYCLES-2 and the last HOLD cycle is the terminal count.
  localparam int            HCW       = (HOLD_CYCLES > 2) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HCW-1:0] HOLD_LOAD = HCW'((HOLD_CYCLES > 2) ? (HOLD_CYCLES - 2) : 0);

  state_t           state, state_n;
  logic [WIDTH-1:0] vec_n;
  logic             valid_n, busy_n, done_n;
  logic             mode, mode_n;
  logic             timer_load, timer_en, hold_expired;
  logic             xfer;

  assign xfer     = vec_valid && vec_ready;
  assign timer_en = (state == HOLD);

  sweep_hold_timer #(
    .CW       (HCW),
    .LOAD_VAL (HOLD_LOAD)
  ) u_hold_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (timer_load),
    .en      (timer_en),
    .expired (hold_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      vec_out   <= '0;
      vec_valid <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mode      <= 1'b0;
    end else begin
      state     <= state_n;
      vec_out   <= vec_n;
      vec_valid <= valid_n;
      busy      <= busy_n;
      done      <= done_n;
      mode      <= mode_n;
    end
  end

  always_comb begin
    state_n    = state;
    vec_n      = vec_out;
    valid_n    = vec_valid;
    busy_n     = busy;
    done_n     = 1'b0;
    mode_n     = mode;
    timer_load = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          state_n = PRESENT;
          vec_n   = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          mode_n  = step_mode;
        end
      end

      PRESENT: begin
        if (xfer) begin
          if (vec_out == LAST_VEC) begin
            state_n = DONE;
            valid_n = 1'b0;
            done_n  = 1'b1;
          end else begin
            vec_n = vec_out + 1'b1;
            if (mode) begin
              state_n = PAUSE;
              valid_n = 1'b0;
            end else if (USE_HOLD) begin
              state_n    = HOLD;
              valid_n    = 1'b0;
              timer_load = 1'b1;
            end
          end
        end
      end

      HOLD: begin
        if (hold_expired) begin
          state_n = PRESENT;
          valid_n = 1'b1;
        end
      end

      PAUSE: begin
        if (step) begin
          state_n = PRESENT;
          valid_n = 1'b1;
        end
      end

      DONE: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end

      default: begin
        state_n = IDLE;
        vec_n   = '0;
        valid_n = 1'b0;
        busy_n  = 1'b0;
      end
    endcase

    // Abort wins over anything the state logic decided, including a transfer.
    if (abort && (state != IDLE)) begin
      state_n    = IDLE;
      vec_n      = '0;
      valid_n    = 1'b0;
      busy_n     = 1'b0;
      done_n     = 1'b0;
      timer_load = 1'b0;
    end
  end

`ifdef SWEEP_RESULT_CAPTURE_EN
  logic cap_clr, cap_we;

  assign cap_clr = (state == IDLE) && start;
  assign cap_we  = xfer && (state == PRESENT) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_f1 <= '0;
      result_f2 <= '0;
    end else if (cap_clr) begin
      result_f1 <= '0;
      result_f2 <= '0;
    end else if (cap_we) begin
      result_f1[vec_out] <= f1_in;
      result_f2[vec_out] <= f2_in;
    end
  end
`else
  logic unused_capture_inputs;

  assign unused_capture_inputs = ^{f1_in, f2_in};
  assign result_f1 = '0;
  assign result_f2 = '0;
`endif

endmodule

// File: tb/tb_abcd_sweep_sequencer.sv
module tb_abcd_sweep_sequencer;
  localparam int W  = 4;
  localparam int NV = 16;
`ifdef SWEEP_RESULT_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n, start, step_mode, step, abort, ready;
  logic [W-1:0]  vec, vec3;
  logic          valid, valid3, busy, busy3, done, done3;
  logic          f1, f2, f1_3, f2_3;
  logic [NV-1:0] rf1, rf2, rf1_3, rf2_3;
  logic [NV-1:0] f1_tab, f2_tab;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  // Decoder stand-in: outputs looked up from a per-vector truth table.
  assign f1   = f1_tab[vec];
  assign f2   = f2_tab[vec];
  assign f1_3 = f1_tab[vec3];
  assign f2_3 = f2_tab[vec3];

  abcd_sweep_sequencer #(.WIDTH(W), .HOLD_CYCLES(1)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .vec_out(vec), .vec_valid(valid), .vec_ready(ready), .busy(busy),
    .done(done), .f1_in(f1), .f2_in(f2), .result_f1(rf1), .result_f2(rf2));

  abcd_sweep_sequencer #(.WIDTH(W), .HOLD_CYCLES(3)) dut_h3 (
    .clk(clk), .rst_n(rst_n), .start(start), .step_mode(step_mode), .step(step),
    .abort(abort), .vec_out(vec3), .vec_valid(valid3), .vec_ready(ready), .busy(busy3),
    .done(done3), .f1_in(f1_3), .f2_in(f2_3), .result_f1(rf1_3), .result_f2(rf2_3));

  task automatic quiesce();
    start = 1'b0; step = 1'b0; abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; step_mode = 1'b0; step = 1'b0; abort = 1'b0; ready = 1'b0;
    f1_tab = '0; f2_tab = '0;
    repeat (3) @(negedge clk);
    vectors++; if ({vec, valid, busy, done} !== '0) begin miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {vec, valid, busy, done}); end
    vectors++; if ({rf1, rf2} !== '0) begin miscompares++;
      $display("FAIL reset_results: got %h expected 0", {rf1, rf2}); end
    vectors++; if ({vec3, valid3, busy3, done3} !== '0) begin miscompares++;
      $display("FAIL reset_outputs_h3: got %h expected 0", {vec3, valid3, busy3, done3}); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({valid, busy, done} !== 3'b000) begin miscompares++;
      $display("FAIL reset_release_idle: got %b expected 000", {valid, busy, done}); end
  endtask

  task automatic test_free_sweep();
    logic [NV-1:0] m1, m2;
    quiesce();
    f1_tab = NV'($urandom()); f2_tab = NV'($urandom());
    m1 = '0; m2 = '0;
    step_mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < NV; i++) begin
      vectors++; if ({valid, vec} !== {1'b1, W'(i)}) begin miscompares++;
        $display("FAIL free_vec[%0d]: got valid=%b vec=%0d expected valid=1 vec=%0d", i, valid, vec, i); end
      vectors++; if ({busy, done} !== 2'b10) begin miscompares++;
        $display("FAIL free_busy_done[%0d]: got %b expected 10", i, {busy, done}); end
      m1[i] = f1_tab[i]; m2[i] = f2_tab[i];
      @(negedge clk);
    end
    vectors++; if ({busy, done, valid} !== 3'b110) begin miscompares++;
      $display("FAIL free_done_pulse: got busy,done,valid=%b expected 110", {busy, done, valid}); end
    @(negedge clk);
    vectors++; if ({busy, done, vec} !== {2'b00, W'(NV - 1)}) begin miscompares++;
      $display("FAIL free_after_done: got busy,done,vec=%b expected 00 and all-ones", {busy, done, vec}); end
    vectors++; if ({rf1, rf2} !== (CAP ? {m1, m2} : '0)) begin miscompares++;
      $display("FAIL free_results: got %h expected %h", {rf1, rf2}, CAP ? {m1, m2} : '0); end
  endtask

  task automatic test_random_ready();
    logic [NV-1:0] m1, m2;
    int n;
    bit finished;
    quiesce();
    f1_tab = NV'($urandom()); f2_tab = NV'($urandom());
    m1 = '0; m2 = '0; n = 0; finished = 1'b0;
    step_mode = 1'b0; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
      if (n < NV) begin
        vectors++; if ({valid, vec, done} !== {1'b1, W'(n), 1'b0}) begin miscompares++;
          $display("FAIL rand_vec: got valid=%b vec=%0d done=%b expected 1 %0d 0", valid, vec, done, n); end
        ready = ($urandom_range(0, 99) < 55);
        if (ready) begin m1[n] = f1_tab[n]; m2[n] = f2_tab[n]; n++; end
      end else begin
        vectors++; if (done !== 1'b1) begin miscompares++;
          $display("FAIL rand_done: got %b expected 1", done); end
        finished = 1'b1;
      end
      @(negedge clk);
    end
    vectors++; if (finished !== 1'b1) begin miscompares++;
      $display("FAIL rand_timeout: got finished=%b expected 1", finished); end
    vectors++; if ({busy, done} !== 2'b00) begin miscompares++;
      $display("FAIL rand_idle: got %b expected 00", {busy, done}); end
    vectors++; if ({rf1, rf2} !== (CAP ? {m1, m2} : '0)) begin miscompares++;
      $display("FAIL rand_results: got %h expected %h", {rf1, rf2}, CAP ? {m1, m2} : '0); end
  endtask

  task automatic test_hold_gap();
    logic [NV-1:0] m1, m2;
    int n, last;
    bit done_seen;
    quiesce();
    f1_tab = NV'($urandom()); f2_tab = NV'($urandom());
    m1 = '0; m2 = '0; n = 0; last = -1; done_seen = 1'b0;
    step_mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 0; cyc < 200 && !done_seen; cyc++) begin
      if (valid3) begin
        vectors++; if (vec3 !== W'(n)) begin miscompares++;
          $display("FAIL hold_vec: got %0d expected %0d", vec3, n); end
        if (last >= 0) begin
          vectors++; if (cyc - last !== 3) begin miscompares++;
            $display("FAIL hold_spacing: got %0d expected 3", cyc - last); end
        end
        last = cyc;
        if (n < NV) begin m1[n] = f1_tab[n]; m2[n] = f2_tab[n]; end
        n++;
      end
      if (done3) done_seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (done_seen !== 1'b1) begin miscompares++;
      $display("FAIL hold_timeout: got done_seen=%b expected 1", done_seen); end
    vectors++; if (n !== NV) begin miscompares++;
      $display("FAIL hold_count: got %0d expected %0d", n, NV); end
    vectors++; if ({rf1_3, rf2_3} !== (CAP ? {m1, m2} : '0)) begin miscompares++;
      $display("FAIL hold_results: got %h expected %h", {rf1_3, rf2_3}, CAP ? {m1, m2} : '0); end
  endtask

  task automatic test_backpressure();
    int guard;
    quiesce();
    step_mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (vec !== W'(7) && guard < 30) begin @(negedge clk); guard++; end
    vectors++; if (vec !== W'(7)) begin miscompares++;
      $display("FAIL bp_reach7: got %0d expected 7", vec); end
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++; if ({valid, vec} !== {1'b1, W'(7)}) begin miscompares++;
        $display("FAIL bp_stall[%0d]: got valid=%b vec=%0d expected 1 7", i, valid, vec); end
    end
    ready = 1'b1;
    @(negedge clk);
    vectors++; if ({valid, vec} !== {1'b1, W'(8)}) begin miscompares++;
      $display("FAIL bp_resume: got valid=%b vec=%0d expected 1 8", valid, vec); end
  endtask

  task automatic test_single_step();
    quiesce();
    step_mode = 1'b1; ready = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; step = 1'b1;
    @(negedge clk);
    vectors++; if ({valid, vec} !== {1'b1, W'(0)}) begin miscompares++;
      $display("FAIL ss_present0: got valid=%b vec=%0d expected 1 0", valid, vec); end
    step = 1'b0; ready = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      vectors++; if ({valid, vec} !== {1'b0, W'(1)}) begin miscompares++;
        $display("FAIL ss_pause_noqueue[%0d]: got valid=%b vec=%0d expected 0 1", i, valid, vec); end
      @(negedge clk);
    end
    for (int k = 1; k < 5; k++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      step = 1'b1;
      @(negedge clk);
      step = 1'b0;
      vectors++; if ({valid, vec} !== {1'b1, W'(k)}) begin miscompares++;
        $display("FAIL ss_step[%0d]: got valid=%b vec=%0d expected 1 %0d", k, valid, vec, k); end
      @(negedge clk);
      vectors++; if ({valid, vec, busy} !== {1'b0, W'(k + 1), 1'b1}) begin miscompares++;
        $display("FAIL ss_pause[%0d]: got valid=%b vec=%0d busy=%b expected 0 %0d 1", k, valid, vec, busy, k + 1); end
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if ({valid, vec, busy, done} !== '0) begin miscompares++;
      $display("FAIL ss_abort: got %b expected 0", {valid, vec, busy, done}); end
  endtask

  task automatic test_capture_abort();
    int f1_set[8] = '{1, 3, 4, 11, 12, 13, 14, 15};
    int f2_set[9] = '{1, 2, 5, 7, 8, 10, 11, 13, 15};
    logic [NV-1:0] mask;
    bit seen;
    int guard;
    quiesce();
    f1_tab = '0; f2_tab = '0;
    foreach (f1_set[i]) f1_tab[f1_set[i]] = 1'b1;
    foreach (f2_set[i]) f2_tab[f2_set[i]] = 1'b1;
    step_mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 1'b0;
    for (int c = 0; c < 40 && !seen; c++) begin
      if (done) seen = 1'b1;
      @(negedge clk);
    end
    vectors++; if (seen !== 1'b1) begin miscompares++;
      $display("FAIL cap_done_timeout: got %b expected 1", seen); end
    vectors++; if ({rf1, rf2} !== (CAP ? 32'hF81A_ADA6 : 32'h0)) begin miscompares++;
      $display("FAIL cap_results: got %h expected %h", {rf1, rf2}, CAP ? 32'hF81A_ADA6 : 32'h0); end
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask = '0; guard = 0;
    while (vec !== W'(9) && guard < 30) begin
      if (valid && ready) mask[vec] = 1'b1;
      @(negedge clk);
      guard++;
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    vectors++; if ({vec, valid, busy, done} !== '0) begin miscompares++;
      $display("FAIL cap_abort_state: got %b expected 0", {vec, valid, busy, done}); end
    for (int c = 0; c < 4; c++) begin
      vectors++; if ({done, busy} !== 2'b00) begin miscompares++;
        $display("FAIL cap_abort_nodone[%0d]: got %b expected 00", c, {done, busy}); end
      @(negedge clk);
    end
    vectors++; if ({rf1, rf2} !== (CAP ? {f1_tab & mask, f2_tab & mask} : '0)) begin miscompares++;
      $display("FAIL cap_abort_results: got %h expected %h", {rf1, rf2}, CAP ? {f1_tab & mask, f2_tab & mask} : '0); end
  endtask

  task automatic test_reset_mid();
    int guard;
    quiesce();
    step_mode = 1'b0; ready = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    guard = 0;
    while (vec !== W'(5) && guard < 30) begin @(negedge clk); guard++; end
    vectors++; if (vec !== W'(5)) begin miscompares++;
      $display("FAIL mid_reach5: got %0d expected 5", vec); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if ({vec, valid, busy, done, rf1, rf2} !== '0) begin miscompares++;
      $display("FAIL mid_async_reset: got %h expected 0", {vec, valid, busy, done, rf1, rf2}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vectors++; if ({vec, valid, busy, done} !== '0) begin miscompares++;
      $display("FAIL mid_idle_after_release: got %b expected 0", {vec, valid, busy, done}); end
  endtask

  initial begin
    test_reset();
    test_free_sweep();
    test_random_ready();
    test_random_ready();
    test_hold_gap();
    test_backpressure();
    test_single_step();
    test_capture_abort();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/abcd_sweep_sequencer.md
Name: abcd_sweep_sequencer

Overview:
- Upstream stimulus stage for the team's 4-input/2-output combinational decoder stages.
- Steps a WIDTH-bit input vector through all 2^WIDTH combinations, starting at 0 and ending at all-ones.
- Presents each vector under a valid/ready handshake, in either a free-running sweep mode or a single-step mode.
- Optionally captures the decoder's two outputs per vector into result words for checking.

Parameters:
- WIDTH, 4, vector width; vec_out[WIDTH-1] drives A and vec_out[0] drives the last input (D for WIDTH=4).
- HOLD_CYCLES, 1, minimum cycles from one transfer to the next vec_valid assertion; must be >= 1. A value of 1 gives back-to-back transfers.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  begin a sweep; sampled only in IDLE.
- step_mode  in  1  0 = free sweep, 1 = single-step; latched when start is accepted.
- step  in  1  advance to the next vector; meaningful in PAUSE only.
- abort  in  1  terminate the sweep; return to IDLE.
- vec_out  out  WIDTH  current vector.
- vec_valid  out  1  vec_out is valid.
- vec_ready  in  1  downstream accepts the vector; a transfer occurs when vec_valid && vec_ready.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse after the final transfer.
- f1_in  in  1  decoder output F1 for vec_out.
- f2_in  in  1  decoder output F2 for vec_out.
- result_f1  out  2^WIDTH  captured F1, bit i corresponds to vector i.
- result_f2  out  2^WIDTH  captured F2, bit i corresponds to vector i.

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE; vec_out=0, vec_valid=0, busy=0, done=0, result_f1=0, result_f2=0; hold counter=0.
- States: IDLE, PRESENT, HOLD, PAUSE, DONE. All outputs are registered.
- IDLE:
  - start=1 -> PRESENT next cycle, with vec_out=0 and vec_valid=1; step_mode is latched.
  - start=1 in any other state is ignored.
- PRESENT:
  - vec_valid=1; vec_out stays stable until a transfer.
  - On a transfer with vec_out == all-ones -> DONE.
  - On any other transfer: vec_out increments (wraps modulo 2^WIDTH, so it never exceeds the all-ones value), vec_valid drops next cycle, and the next state is:
    - step_mode=1 -> PAUSE;
    - step_mode=0 and HOLD_CYCLES>1 -> HOLD;
    - step_mode=0 and HOLD_CYCLES=1 -> stays in PRESENT with vec_valid=1 (no bubble).
- HOLD:
  - vec_valid=0; a counter runs HOLD_CYCLES-1 cycles, then -> PRESENT.
  - Transfer-to-transfer spacing is therefore exactly HOLD_CYCLES cycles when ready is always high.
- PAUSE:
  - vec_valid=0; waits for step=1 -> PRESENT.
  - A step asserted outside PAUSE is ignored; it is not queued.
- DONE:
  - done=1 for exactly one cycle, then -> IDLE.
  - vec_out holds the all-ones value until the next start.
- abort=1 in any non-IDLE state:
  - next cycle: IDLE, vec_valid=0, vec_out=0.
  - result registers are retained; no done pulse.
  - abort has priority over a transfer in the same cycle.
- Ready stall: vec_ready=0 indefinitely keeps the sequencer in PRESENT with vec_out unchanged.
- Total transfers per completed sweep: exactly 2^WIDTH.

Optional Feature:
- Macro: SWEEP_RESULT_CAPTURE_EN.
- Defined:
  - On each transfer, f1_in is written to result_f1[vec_out] and f2_in to result_f2[vec_out].
  - Both result words clear to 0 when start is accepted.
- Undefined:
  - Ports are still present; f1_in and f2_in are ignored; result_f1 and result_f2 are tied to 0; no storage is inferred.

Decomposition:
- Package sweep_pkg:
  - state enum (IDLE, PRESENT, HOLD, PAUSE, DONE);
  - default WIDTH and HOLD_CYCLES constants;
  - function last_vec(width), returning the all-ones value.
- One sub-module, sweep_hold_timer:
  - loadable down-counter for the HOLD gap;
  - inputs: load, en; output: expired.
- Vector register, FSM and capture logic remain in the top module.

Test Plan:
- Reset mid-sweep (rst_n low while vec_out=5) -> all outputs 0 asynchronously; IDLE after release; busy=0.
- Free sweep: HOLD_CYCLES=1, ready=1, start pulse -> vec_out 0..15 on 16 consecutive cycles with valid high; done pulses on the cycle after vec 15's transfer; busy falls with done.
- Hold gap: HOLD_CYCLES=3 -> transfers exactly 3 cycles apart; vec_valid low for 2 cycles between them; 16 transfers in total.
- Backpressure: ready=0 for 5 cycles at vec 7 -> vec_out stays 7 with valid=1; ready=1 -> transfer; vec 8 follows.
- Single-step: step_mode=1 -> a transfer of vec 0, then PAUSE with valid=0; step asserted while in PRESENT is ignored; each step advances exactly one vector.
- Capture (macro defined): f1_in driven high for vectors {1,3,4,11,12,13,14,15} and f2_in high for vectors {1,2,5,7,8,10,11,13,15} -> result_f1=16'hF81A, result_f2=16'hADA6. Repeat with abort at vec 9 -> no done pulse; results retained; vec_out=0.
